// File: rtl/primos_pares_contador.sv
// primos_pares_contador: tallies prime/even categories over a frame of
// classified nibbles, recomputes both flags to count classifier errors, and
// presents the results through a DONE/ACK handshake.
module primos_pares_contador #(
  parameter int FRAME_LEN = 16,
  parameter int CW        = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          VALID,
  input  logic          D,
  input  logic          C,
  input  logic          B,
  input  logic          A,
  input  logic          PRIMOS,
  input  logic          PARES,
  input  logic          ACK,
  output logic          BUSY,
  output logic          DONE,
  output logic [CW-1:0] CNT_PRIMOS,
  output logic [CW-1:0] CNT_PARES,
  output logic [CW-1:0] CNT_AMBOS,
  output logic [CW-1:0] CNT_NINGUNO,
  output logic [CW-1:0] CNT_ERR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACUM  = 2'd1,
    LISTO = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] idx;
  logic [3:0]    nibble;
  logic          ref_prime;
  logic          ref_even;
  logic          accept;
  logic          last_sample;
  logic          start_frame;
  logic          sample_err;

  assign nibble      = {D, C, B, A};
  assign accept      = (state == ACUM) && VALID;
  assign last_sample = accept && (idx == CW'(FRAME_LEN - 1));
  assign start_frame = (state == IDLE) && START;

  // Status outputs decoded from the registered state only.
  assign BUSY = (state == ACUM);
  assign DONE = (state == LISTO);

  // Reference classification of the incoming nibble.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    ref_prime = 1'b0;
    case (nibble)
      4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: ref_prime = 1'b1;
      default:                              ref_prime = 1'b0;
    endcase
  end

  assign ref_even   = ~A;
  assign sample_err = (PRIMOS != ref_prime) || (PARES != ref_even);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (START)       state_next = ACUM;
      ACUM:    if (last_sample) state_next = LISTO;
      LISTO:   if (ACK)         state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Sample index and category counters: cleared on START, bumped per accepted sample.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx         <= '0;
      CNT_PRIMOS  <= '0;
      CNT_PARES   <= '0;
      CNT_AMBOS   <= '0;
      CNT_NINGUNO <= '0;
      CNT_ERR     <= '0;
    end else if (start_frame) begin
      idx         <= '0;
      CNT_PRIMOS  <= '0;
      CNT_PARES   <= '0;
      CNT_AMBOS   <= '0;
      CNT_NINGUNO <= '0;
      CNT_ERR     <= '0;
    end else if (accept) begin
      idx         <= idx + CW'(1);
      CNT_PRIMOS  <= CNT_PRIMOS  + CW'(PRIMOS);
      CNT_PARES   <= CNT_PARES   + CW'(PARES);
      CNT_AMBOS   <= CNT_AMBOS   + CW'(PRIMOS & PARES);
      CNT_NINGUNO <= CNT_NINGUNO + CW'(~PRIMOS & ~PARES);
      CNT_ERR     <= CNT_ERR     + CW'(sample_err);
    end
  end

endmodule
